alien_formation_mover: RTL
==========================

// Module: alien_formation_mover
// PURPOSE
//  Motion executor for the alien formation: consumes the one-hot Motion command from the zig-zag controller.
//  Keeps the formation's top-left X/Y coordinates.
//  Produces the canLeft/canRight permissions that close the loop back to the controller.
//  Raises a sticky landed flag when the formation reaches the bottom row (invasion / game-over input).
// PARAMETERS
//  COORD_W      10    coordinate width in bits (X and Y)
//  X_MIN        0     leftmost legal X of the formation's left edge
//  X_MAX        639   rightmost legal X of the formation's right edge (inclusive)
//  FORMATION_W  320   formation width in pixels; right edge = alienX + FORMATION_W - 1
//  X_START      16    alienX after reset/restart
//  Y_START      32    alienY after reset/restart
//  Y_BOTTOM     400   alienY at which the formation has landed
//  STEP_X       8     pixels per LEFT/RIGHT move
//  STEP_Y       16    pixels per DOWN move
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-low reset (0 = reset)
//  enable     in   1        move tick, one-cycle pulse, same tick that drives the zig-zag controller
//  restart    in   1        synchronous reload of start position (new wave)
//  Motion     in   3        one-hot command: 100 RIGHT, 010 DOWN, 001 LEFT, 000 none
//  canLeft    out  1        a LEFT step fits: alienX - STEP_X >= X_MIN and not landed
//  canRight   out  1        a RIGHT step fits: alienX + FORMATION_W - 1 + STEP_X <= X_MAX and not landed
//  alienX     out  COORD_W  formation left edge
//  alienY     out  COORD_W  formation top edge
//  landed     out  1        sticky, formation reached Y_BOTTOM
//  moved      out  1        one-cycle pulse, position changed on the previous edge
//  badMotion  out  1        one-cycle pulse, illegal Motion (2+ bits set) seen on an enable tick
//  moveCount  out  16       executed moves since reset/restart, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset==0): alienX=X_START, alienY=Y_START; landed=moved=badMotion=0; moveCount=0.
//  - canLeft/canRight are combinational from the registered alienX and landed only.
//    They never depend on Motion, so the loop through the zig-zag controller is acyclic.
//  - Bound arithmetic is done in COORD_W+1 bits: no wrap below 0 or above 2^COORD_W-1.
//  - Priority per edge: reset > restart > enable > hold.
//  - restart=1: reload X_START/Y_START; clear landed and moveCount; moved=1 iff the position changed; ignore enable.
//  - enable=1, landed=0, restart=0: decode Motion, 1-cycle latency to alienX/alienY.
//      100: if canRight then alienX += STEP_X, else hold.
//      001: if canLeft then alienX -= STEP_X, else hold.
//      010: if alienY + STEP_Y >= Y_BOTTOM then alienY = Y_BOTTOM and landed = 1 on the same edge;
//           otherwise alienY += STEP_Y.
//      000: hold.
//      other: hold, badMotion=1 for one cycle.
//  - A move refused by a bound or by landed is a hold: moved=0, moveCount unchanged.
//  - Each executed move: moved=1 next cycle, moveCount+1 (saturating).
//  - enable=0: all registers hold; moved and badMotion return to 0.
//  - landed=1: canLeft=canRight=0, which drives the controller to NO_MOTION.
//    All further Motion is ignored, DOWN included; only restart or reset clears it.
//  - Reset mid-move wins over every other input on the same edge.
// TESTING
//  1 Reset, then 5 enables with Motion=100 (defaults) -> alienX 16,24,32,40,56? no: 24,32,40,48,56; moved pulses 5x; moveCount=5.
//  2 Force alienX=312 via RIGHT steps -> canRight=0 at 320+... check: alienX=312 gives edge 631, +8=639 ok; at 320 canRight=0; further 100 holds alienX, moved=0.
//  3 LEFT from alienX=8 -> alienX=0, canLeft=0; next 001 holds at 0, no underflow.
//  4 DOWN from alienY=384 -> alienY=400, landed=1, canLeft=canRight=0; next DOWN/RIGHT ignored, moveCount frozen.
//  5 restart with enable=1 and Motion=100 while landed -> alienX=16, alienY=32, landed=0, moveCount=0.
//  6 Motion=110 on enable -> position holds, badMotion one-cycle pulse; reset low mid-sequence -> all outputs at reset values next edge.

Source files
------------

// File: rtl/alien_formation_mover.sv
// Motion executor for the alien formation: applies one-hot move commands to the
// formation's top-left coordinates and reports left/right step permissions and landing.
module alien_formation_mover #(
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned X_MIN       = 0,
   parameter int unsigned X_MAX       = 639,
   parameter int unsigned FORMATION_W = 320,
   parameter int unsigned X_START     = 16,
   parameter int unsigned Y_START     = 32,
   parameter int unsigned Y_BOTTOM    = 400,
   parameter int unsigned STEP_X      = 8,
   parameter int unsigned STEP_Y      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               restart,
   input  logic [2:0]         Motion,
   output logic               canLeft,
   output logic               canRight,
   output logic [COORD_W-1:0] alienX,
   output logic [COORD_W-1:0] alienY,
   output logic               landed,
   output logic               moved,
   output logic               badMotion,
   output logic [15:0]        moveCount
);

   localparam int unsigned EXT_W = COORD_W + 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      MOT_NONE  = 3'b000,
      MOT_LEFT  = 3'b001,
      MOT_DOWN  = 3'b010,
      MOT_RIGHT = 3'b100
   } motion_e;

   logic [EXT_W-1:0]   x_ext;
   logic [EXT_W-1:0]   right_edge_next;
   logic [EXT_W-1:0]   y_down;
   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y_nxt;
   logic               landed_nxt;
   logic               step;
   logic               bad_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               at_start;

   // Bound checks in one extra bit so neither edge can wrap; driven only by registered state.
   assign x_ext           = EXT_W'(alienX);
   assign right_edge_next = x_ext + EXT_W'(FORMATION_W - 1 + STEP_X);
   assign y_down          = EXT_W'(alienY) + EXT_W'(STEP_Y);
   assign canRight        = !landed && (right_edge_next <= EXT_W'(X_MAX));
   assign canLeft         = !landed && (x_ext >= EXT_W'(X_MIN + STEP_X));
   assign at_start        = (alienX == COORD_W'(X_START)) && (alienY == COORD_W'(Y_START));

   // Decode one move tick into next position, landing and pulse flags.
   always_comb begin
      x_nxt      = alienX;
      y_nxt      = alienY;
      landed_nxt = landed;
      step       = 1'b0;
      bad_nxt    = 1'b0;
      if (enable && !landed) begin
         case (Motion)
            MOT_RIGHT: begin
               if (canRight) begin
                  x_nxt = alienX + COORD_W'(STEP_X);
                  step  = 1'b1;
               end
            end
            MOT_LEFT: begin
               if (canLeft) begin
                  x_nxt = alienX - COORD_W'(STEP_X);
                  step  = 1'b1;
               end
            end
            MOT_DOWN: begin
               step = 1'b1;
               if (y_down >= EXT_W'(Y_BOTTOM)) begin
                  y_nxt      = COORD_W'(Y_BOTTOM);
                  landed_nxt = 1'b1;
               end else begin
                  y_nxt = y_down[COORD_W-1:0];
               end
            end
            MOT_NONE: begin
            end
            default: bad_nxt = 1'b1;
         endcase
      end
      cnt_nxt = (step && (moveCount != {CNT_W{1'b1}})) ? moveCount + CNT_W'(1) : moveCount;
   end

   // State update: reset > restart > move tick > hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alienX    <= COORD_W'(X_START);
         alienY    <= COORD_W'(Y_START);
         landed    <= 1'b0;
         moved     <= 1'b0;
         badMotion <= 1'b0;
         moveCount <= '0;
      end else if (restart) begin
         alienX    <= COORD_W'(X_START);
         alienY    <= COORD_W'(Y_START);
         landed    <= 1'b0;
         moved     <= !at_start;
         badMotion <= 1'b0;
         moveCount <= '0;
      end else begin
         alienX    <= x_nxt;
         alienY    <= y_nxt;
         landed    <= landed_nxt;
         moved     <= step;
         badMotion <= bad_nxt;
         moveCount <= cnt_nxt;
      end
   end

endmodule
